ahb2apb_bridge_param: RTL

Parametrised AHB-Lite to APB3 bridge: a single-instance successor to the fixed three-slave bridge top. It accepts single AHB transfers and decodes them to one of `NUM_SLV` APB slaves. It extends the earlier bridge with `Pready` wait states, `Pslverr` propagation, out-of-range decode errors and an optional `Pready` timeout, all mapped to a two-cycle AHB ERROR response. It sits between the AHB interconnect and the peripheral APB segment.

---
 rtl/ahb2apb_bridge_param.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ahb2apb_bridge_param.sv
// AHB-Lite to APB3 bridge: single transfers decoded to NUM_SLV slaves,
// with wait states, slave/decode errors and an optional Pready timeout.
module ahb2apb_bridge_param #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                NUM_SLV   = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int                SLV_SHIFT = 24,
    parameter int                TIMEOUT   = 0
) (
    input  logic                      Hclk,
    input  logic                      Hresetn,
    input  logic                      Hwrite,
    input  logic                      Hreadyin,
    input  logic [1:0]                Htrans,
    input  logic [ADDR_W-1:0]         Haddr,
    input  logic [DATA_W-1:0]         Hwdata,
    output logic                      Hreadyout,
    output logic [1:0]                Hresp,
    output logic [DATA_W-1:0]         Hrdata,
    output logic [NUM_SLV-1:0]        Pselx,
    output logic                      Penable,
    output logic                      Pwrite,
    output logic [ADDR_W-1:0]         Paddr,
    output logic [DATA_W-1:0]         Pwdata,
    input  logic [NUM_SLV*DATA_W-1:0] Prdata,
    input  logic [NUM_SLV-1:0]        Pready,
    input  logic [NUM_SLV-1:0]        Pslverr
);

    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_WWAIT, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [NUM_SLV-1:0]  psel_q, psel_d;
    logic                penable_q, penable_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [ADDR_W-1:0]   off, off_sh;
    logic [IDX_W-1:0]    dec_idx;
    logic                in_range, valid, sel_rdy, sel_err, timeout, decode;
    logic                unused_htrans0;

    assign unused_htrans0 = Htrans[0];

    // Shift the offset rather than the window size so large windows cannot overflow
    assign off      = Haddr - BASE_ADDR;
    assign off_sh   = off >> SLV_SHIFT;
    assign in_range = (Haddr >= BASE_ADDR) && (off_sh < ADDR_W'(NUM_SLV));
    assign dec_idx  = off_sh[IDX_W-1:0];
    assign valid    = Hreadyin && Htrans[1] && Hreadyout;
    assign sel_rdy  = Pready[idx_q];
    assign sel_err  = Pslverr[idx_q];
    assign timeout  = (TIMEOUT != 0) && (state_q == S_ACCESS) && !sel_rdy
                      && (cnt_q == CNT_LAST);

    always_comb begin
        Hreadyout = 1'b1;
        Hresp     = 2'b00;
        Hrdata    = '0;
        unique case (state_q)
            S_WWAIT, S_SETUP: Hreadyout = 1'b0;
            S_ACCESS: begin
                Hreadyout = sel_rdy && !sel_err;
                if (sel_rdy) begin
                    Hrdata = Prdata[int'(idx_q) * DATA_W +: DATA_W];
                    if (sel_err) Hresp = 2'b01;
                end
            end
            S_ERR1: begin
                Hreadyout = 1'b0;
                Hresp     = 2'b01;
            end
            S_ERR2:  Hresp = 2'b01;
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        cnt_d    = cnt_q;
        decode   = 1'b0;
        unique case (state_q)
            S_IDLE, S_ERR2: decode = 1'b1;
            S_WWAIT: begin
                pwdata_d = Hwdata;
                state_d  = S_SETUP;
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                if (sel_rdy) begin
                    if (sel_err) state_d = S_ERR2;
                    else         decode  = 1'b1;
                end else if (timeout) begin
                    // ERR1 gives the first error cycle with the APB bus released
                    state_d = S_ERR1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase

        if (decode) begin
            state_d = S_IDLE;
            if (valid) begin
                if (in_range) begin
                    state_d  = Hwrite ? S_WWAIT : S_SETUP;
                    idx_d    = dec_idx;
                    paddr_d  = Haddr;
                    pwrite_d = Hwrite;
                end else begin
                    state_d = S_ERR1;
                end
            end
        end

        if (state_d == S_SETUP) begin
            cnt_d = '0;
        end else if ((TIMEOUT != 0) && (state_q == S_ACCESS) && !sel_rdy
                     && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end

        psel_d    = '0;
        penable_d = (state_d == S_ACCESS);
        if ((state_d == S_SETUP) || (state_d == S_ACCESS))
            psel_d = NUM_SLV'(1) << idx_d;
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            cnt_q     <= cnt_d;
        end
    end

    assign Pselx   = psel_q;
    assign Penable = penable_q;
    assign Pwrite  = pwrite_q;
    assign Paddr   = paddr_q;
    assign Pwdata  = pwdata_q;

endmodule
